// File: rtl/soc_system_pio_pkg.sv
// Shared constants and helpers for the soc_system Avalon-MM PIO family.
package soc_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum int {
    EDGE_RISE = 0,
    EDGE_FALL = 1,
    EDGE_ANY  = 2
  } edge_type_e;

  // Zero-extends the low `width` bits of a register onto the 32-bit read bus.
  function automatic logic [31:0] zext32(input logic [31:0] value, input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return value & mask;
  endfunction

endpackage

// File: rtl/soc_system_pio_sync.sv
// Per-bit multi-flop synchroniser for asynchronous PIO inputs.
module soc_system_pio_sync #(
  parameter int unsigned WIDTH  = 13,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/soc_system_pio_in_edge.sv
// Avalon-MM input PIO with synchronised data, per-bit edge capture (W1C),
// interrupt mask and level IRQ.
module soc_system_pio_in_edge
  import soc_system_pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 13,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int          EDGE_TYPE   = 0,
  parameter int          IRQ_EN      = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam int unsigned ARM_MAX = SYNC_STAGES + 1;

  logic [DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] irq_mask;
  logic [DATA_WIDTH-1:0] edge_capture;
  logic [DATA_WIDTH-1:0] edge_vec;
  logic [DATA_WIDTH-1:0] clr;
  logic [2:0]            arm_cnt;
  logic                  armed;
  logic                  wr_en;
  logic [31:0]           rd_mux;
  logic                  unused_wd;

  soc_system_pio_sync #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (sync_q)
  );

  assign wr_en     = chipselect & ~write_n;
  assign armed     = (arm_cnt == 3'(ARM_MAX));
  assign clr       = (wr_en && address == ADDR_EDGE) ? writedata[DATA_WIDTH-1:0] : '0;
  assign unused_wd = ^writedata;

  always_comb begin
    edge_vec = sync_q & ~prev_q;
    if (EDGE_TYPE == int'(EDGE_FALL))     edge_vec = ~sync_q & prev_q;
    else if (EDGE_TYPE == int'(EDGE_ANY)) edge_vec = sync_q ^ prev_q;
  end

  // Arming holds off capture until prev has seen the first synchronised
  // value, so inputs already high at reset release are not taken as edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    arm_cnt <= '0;
    else if (!armed) arm_cnt <= arm_cnt + 3'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q       <= '0;
      edge_capture <= '0;
      irq_mask     <= '0;
    end else begin
      prev_q       <= sync_q;
      edge_capture <= (edge_capture & ~clr) | (edge_vec & {DATA_WIDTH{armed}});
      if (IRQ_EN != 0 && wr_en && address == ADDR_MASK)
        irq_mask <= writedata[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux = zext32(32'(sync_q), DATA_WIDTH);
      ADDR_MASK: rd_mux = zext32(32'(irq_mask), DATA_WIDTH);
      ADDR_EDGE: rd_mux = zext32(32'(edge_capture), DATA_WIDTH);
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = (IRQ_EN != 0) ? |(edge_capture & irq_mask) : 1'b0;

endmodule
